// File: rtl/approx_mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mult_pkg
//  Description : Shared constants and parameter-legality helper for the
//                pipelined approximate multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package approx_mult_pkg;

    // Per-transaction mode encoding
    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // The low approximated rows are compressed in pairs, so L must be even.
    // The low rows must also fit in the operand, and the truncation column
    // must fall within the product.
    function automatic bit params_legal(input int w, input int l, input int trunc_col);
        return (w > 0) && (l >= 0) && (l <= w) && ((l % 2) == 0) &&
               (trunc_col >= 0) && (trunc_col <= 2 * w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/approx_pp_compress.sv
`default_nettype none
// ============================================================================
//  Module      : approx_pp_compress
//  Description : Combinational partial-product stage. Produces the exact high
//                row (x bits L..W-1) and the low row (x bits 0..L-1), which is
//                either exact or pairwise OR-compressed and truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_pp_compress
    import approx_mult_pkg::*;
#(
    parameter int W         = 8,
    parameter int L         = 6,
    parameter int TRUNC_COL = W
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    input  logic           mode,
    output logic [2*W-1:0] hi_row,
    output logic [2*W-1:0] lo_row
);

    localparam int P = 2 * W;

    // Columns below TRUNC_COL are dropped from every compressed pair
    function automatic logic [P-1:0] keep_mask();
        logic [P-1:0] m;
        for (int c = 0; c < P; c++) begin
            m[c] = (c >= TRUNC_COL);
        end
        return m;
    endfunction

    localparam logic [P-1:0] C_KEEP_MASK = keep_mask();

    logic [P-1:0] w_pp;
    logic [P-1:0] w_pair;
    logic [P-1:0] w_hi;
    logic [P-1:0] w_lo_exact;
    logic [P-1:0] w_lo_approx;

    // Walk the rows once: high rows sum exactly, low rows feed both the exact
    // low sum and the OR-pair compressor (even row opens a pair, odd closes it)
    always_comb begin
        w_pp        = '0;
        w_pair      = '0;
        w_hi        = '0;
        w_lo_exact  = '0;
        w_lo_approx = '0;
        for (int i = 0; i < W; i++) begin
            w_pp = ({{W{1'b0}}, y} & {P{x[i]}}) << i;
            if (i >= L) begin
                w_hi = w_hi + w_pp;
            end else begin
                w_lo_exact = w_lo_exact + w_pp;
                if ((i % 2) == 0) begin
                    w_pair = w_pp;
                end else begin
                    w_lo_approx = w_lo_approx + ((w_pair | w_pp) & C_KEEP_MASK);
                end
            end
        end
    end

    assign hi_row = w_hi;
    assign lo_row = (mode == MODE_APPROX) ? w_lo_approx : w_lo_exact;

endmodule
`default_nettype wire

// File: rtl/approx_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : approx_mult_pipe
//  Description : Three-stage stall-all pipelined W x W multiplier with a
//                per-beat exact/approximate mode and tag passthrough.
//                S1: operands, S2: high/low rows, S3: final sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int W         = 8,
    parameter int L         = 6,
    parameter int TRUNC_COL = W,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             mode,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   z,
    output logic [TAG_W-1:0] tag_out,
    output logic             out_mode
);

    generate
        if (!params_legal(W, L, TRUNC_COL)) begin : g_bad_params
            $fatal(1, "approx_mult_pipe: illegal W/L/TRUNC_COL combination");
        end
    endgenerate

    localparam int P = 2 * W;

    // Stage registers
    logic             r_s1_valid_q, w_s1_valid_d;
    logic [W-1:0]     r_s1_x_q,     w_s1_x_d;
    logic [W-1:0]     r_s1_y_q,     w_s1_y_d;
    logic             r_s1_mode_q,  w_s1_mode_d;
    logic [TAG_W-1:0] r_s1_tag_q,   w_s1_tag_d;

    logic             r_s2_valid_q, w_s2_valid_d;
    logic [P-1:0]     r_s2_hi_q,    w_s2_hi_d;
    logic [P-1:0]     r_s2_lo_q,    w_s2_lo_d;
    logic             r_s2_mode_q,  w_s2_mode_d;
    logic [TAG_W-1:0] r_s2_tag_q,   w_s2_tag_d;

    logic             r_s3_valid_q, w_s3_valid_d;
    logic [P-1:0]     r_s3_z_q,     w_s3_z_d;
    logic             r_s3_mode_q,  w_s3_mode_d;
    logic [TAG_W-1:0] r_s3_tag_q,   w_s3_tag_d;

    logic             w_advance;
    logic [P-1:0]     w_hi_row;
    logic [P-1:0]     w_lo_row;

    // The whole pipe moves together; it only freezes when a result is
    // waiting and the consumer is not taking it
    assign w_advance = !r_s3_valid_q || out_ready;
    assign in_ready  = w_advance;

    approx_pp_compress #(
        .W         (W),
        .L         (L),
        .TRUNC_COL (TRUNC_COL)
    ) u_compress (
        .x      (r_s1_x_q),
        .y      (r_s1_y_q),
        .mode   (r_s1_mode_q),
        .hi_row (w_hi_row),
        .lo_row (w_lo_row)
    );

    // Next-state: hold everything by default, shift every stage on advance
    always_comb begin
        w_s1_valid_d = r_s1_valid_q;
        w_s1_x_d     = r_s1_x_q;
        w_s1_y_d     = r_s1_y_q;
        w_s1_mode_d  = r_s1_mode_q;
        w_s1_tag_d   = r_s1_tag_q;
        w_s2_valid_d = r_s2_valid_q;
        w_s2_hi_d    = r_s2_hi_q;
        w_s2_lo_d    = r_s2_lo_q;
        w_s2_mode_d  = r_s2_mode_q;
        w_s2_tag_d   = r_s2_tag_q;
        w_s3_valid_d = r_s3_valid_q;
        w_s3_z_d     = r_s3_z_q;
        w_s3_mode_d  = r_s3_mode_q;
        w_s3_tag_d   = r_s3_tag_q;
        if (w_advance) begin
            w_s1_valid_d = in_valid;
            w_s1_x_d     = x;
            w_s1_y_d     = y;
            w_s1_mode_d  = mode;
            w_s1_tag_d   = tag_in;
            w_s2_valid_d = r_s1_valid_q;
            w_s2_hi_d    = w_hi_row;
            w_s2_lo_d    = w_lo_row;
            w_s2_mode_d  = r_s1_mode_q;
            w_s2_tag_d   = r_s1_tag_q;
            w_s3_valid_d = r_s2_valid_q;
            w_s3_z_d     = r_s2_hi_q + r_s2_lo_q;
            w_s3_mode_d  = r_s2_mode_q;
            w_s3_tag_d   = r_s2_tag_q;
        end
    end

    // Pipeline registers; reset drops all in-flight beats and zeroes outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q <= 1'b0;
            r_s1_x_q     <= '0;
            r_s1_y_q     <= '0;
            r_s1_mode_q  <= MODE_EXACT;
            r_s1_tag_q   <= '0;
            r_s2_valid_q <= 1'b0;
            r_s2_hi_q    <= '0;
            r_s2_lo_q    <= '0;
            r_s2_mode_q  <= MODE_EXACT;
            r_s2_tag_q   <= '0;
            r_s3_valid_q <= 1'b0;
            r_s3_z_q     <= '0;
            r_s3_mode_q  <= MODE_EXACT;
            r_s3_tag_q   <= '0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_x_q     <= w_s1_x_d;
            r_s1_y_q     <= w_s1_y_d;
            r_s1_mode_q  <= w_s1_mode_d;
            r_s1_tag_q   <= w_s1_tag_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_s2_hi_q    <= w_s2_hi_d;
            r_s2_lo_q    <= w_s2_lo_d;
            r_s2_mode_q  <= w_s2_mode_d;
            r_s2_tag_q   <= w_s2_tag_d;
            r_s3_valid_q <= w_s3_valid_d;
            r_s3_z_q     <= w_s3_z_d;
            r_s3_mode_q  <= w_s3_mode_d;
            r_s3_tag_q   <= w_s3_tag_d;
        end
    end

    assign out_valid = r_s3_valid_q;
    assign z         = r_s3_z_q;
    assign tag_out   = r_s3_tag_q;
    assign out_mode  = r_s3_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_approx_mult_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_approx_mult_pipe
//  Description : Self-checking bench for approx_mult_pipe. Directed vector
//                table on W=8/L=6/TRUNC_COL=8, random streams with and without
//                backpressure, mid-stream reset, and an exhaustive sweep of a
//                W=4/L=2/TRUNC_COL=0 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_approx_mult_pipe;

    localparam int W  = 8;
    localparam int L  = 6;
    localparam int TC = 8;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, mode = 1'b0;
    logic [W-1:0]  x = '0, y = '0;
    logic [TW-1:0] tag_in = '0, tag_out;
    logic          out_valid, out_ready = 1'b0, out_mode;
    logic [2*W-1:0] z;

    approx_mult_pipe #(.W(W), .L(L), .TRUNC_COL(TC), .TAG_W(TW)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .mode(mode), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .tag_out(tag_out), .out_mode(out_mode)
    );

    // Small second instance for the exhaustive sweep
    logic          b_in_valid = 1'b0, b_in_ready, b_mode = 1'b0;
    logic [3:0]    b_x = '0, b_y = '0;
    logic [TW-1:0] b_tag_in = '0, b_tag_out;
    logic          b_out_valid, b_out_mode;
    logic [7:0]    b_z;

    approx_mult_pipe #(.W(4), .L(2), .TRUNC_COL(0), .TAG_W(TW)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x(b_x), .y(b_y), .mode(b_mode), .tag_in(b_tag_in),
        .out_valid(b_out_valid), .out_ready(1'b1),
        .z(b_z), .tag_out(b_tag_out), .out_mode(b_out_mode)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: straight from the arithmetic definition
    function automatic logic [63:0] ref_mul(input int w, input int l, input int tc,
                                            input logic [63:0] a, input logic [63:0] b,
                                            input logic m);
        logic [63:0] r, t;
        if (!m) begin
            r = a * b;
        end else begin
            r = (b * (a >> l)) << l;
            for (int k = 0; k < l / 2; k++) begin
                t = 64'd0;
                if (a[2*k])   t = t | (b << (2*k));
                if (a[2*k+1]) t = t | (b << (2*k+1));
                t = t & ~((64'd1 << tc) - 64'd1);
                r = r + t;
            end
        end
        return r & ((64'd1 << (2*w)) - 64'd1);
    endfunction

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        mode;
        logic [3:0]  tag;
        logic [15:0] z;
    } vec_t;

    typedef struct {
        logic [15:0] z;
        logic [3:0]  tag;
        logic        mode;
    } exp_t;

    vec_t vecs[12];
    exp_t q[$];
    exp_t bq[$];

    // Random stream on the main instance with optional backpressure; checks
    // order, tags, stability while stalled and the in_ready relation
    task automatic stream(input int n_beats, input int bp_pct);
        int          sent = 0;
        int          cycles = 0;
        int          budget = n_beats * 6 + 50;
        logic        held = 1'b0;
        logic [15:0] h_z = '0;
        logic [3:0]  h_tag = '0;
        logic        h_mode = 1'b0;
        exp_t        e;
        while ((sent < n_beats || q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
            cycles++;
            out_ready = ($urandom_range(99) >= bp_pct);
            #1;
            if (held) begin
                check("stall_z", z, h_z);
                check("stall_tag", tag_out, h_tag);
                check("stall_mode", out_mode, h_mode);
            end
            check("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_result", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("stream_z", z, e.z);
                    check("stream_tag", tag_out, e.tag);
                    check("stream_mode", out_mode, e.mode);
                end
            end
            held   = out_valid && !out_ready;
            h_z    = z;
            h_tag  = tag_out;
            h_mode = out_mode;
            if (sent < n_beats && (bp_pct == 0 || $urandom_range(99) < 80)) begin
                in_valid = 1'b1;
                x        = W'($urandom);
                y        = W'($urandom);
                mode     = sent[0];
                tag_in   = TW'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                e.z    = 16'(ref_mul(W, L, TC, 64'(x), 64'(y), mode));
                e.tag  = tag_in;
                e.mode = mode;
                q.push_back(e);
                sent++;
            end
        end
        in_valid = 1'b0;
        if (budget == 0) check("stream_timeout", 0, 1);
        // No backpressure: one beat per cycle plus three cycles of fill
        if (bp_pct == 0) check("throughput_cycles", cycles, n_beats + 3);
    endtask

    initial begin
        //            x    y    mode tag  z
        vecs[0]  = '{8'd255, 8'd255, 1'b1, 4'd5,  16'd58944};
        vecs[1]  = '{8'd255, 8'd255, 1'b0, 4'd6,  16'd65025};
        vecs[2]  = '{8'd3,   8'd255, 1'b1, 4'd7,  16'd256};
        vecs[3]  = '{8'd64,  8'd200, 1'b1, 4'd8,  16'd12800};
        vecs[4]  = '{8'd64,  8'd200, 1'b0, 4'd9,  16'd12800};
        vecs[5]  = '{8'd0,   8'd123, 1'b1, 4'd10, 16'd0};
        vecs[6]  = '{8'd1,   8'd1,   1'b1, 4'd11, 16'd0};
        vecs[7]  = '{8'd1,   8'd1,   1'b0, 4'd12, 16'd1};
        vecs[8]  = '{8'd128, 8'd255, 1'b1, 4'd13, 16'd32640};
        vecs[9]  = '{8'd170, 8'd85,  1'b0, 4'd14, 16'd14450};
        vecs[10] = '{8'd170, 8'd85,  1'b1, 4'd15, 16'd13952};
        vecs[11] = '{8'd255, 8'd1,   1'b1, 4'd0,  16'd192};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_z", z, 0);
        check("rst_tag_out", tag_out, 0);
        check("rst_out_mode", out_mode, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed table: three registers, so a beat accepted at one edge is
        // visible after the second edge that follows it
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            in_valid = 1'b1;
            x = vecs[i].x; y = vecs[i].y; mode = vecs[i].mode; tag_in = vecs[i].tag;
            @(negedge clk);
            in_valid = 1'b0;
            check("lat_s1_idle", out_valid, 0);
            @(negedge clk);
            check("lat_s2_idle", out_valid, 0);
            @(negedge clk);
            check("lat_out_valid", out_valid, 1);
            check("vec_z", z, vecs[i].z);
            check("vec_tag", tag_out, vecs[i].tag);
            check("vec_mode", out_mode, vecs[i].mode);
        end
        @(negedge clk);
        check("vec_drained", out_valid, 0);

        stream(100, 0);
        stream(150, 50);

        // Fill the pipe under a stalled consumer, then reset it
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; x = 8'(i + 20); y = 8'd7; mode = 1'b0; tag_in = 4'(i + 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        rst = 1'b1;
        in_valid = 1'b1; x = 8'd9; y = 8'd9;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_ghost", out_valid, 0);
        end
        in_valid = 1'b1; x = 8'd12; y = 8'd11; mode = 1'b0; tag_in = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_latency", out_valid, 0);
        @(negedge clk);
        check("post_rst_valid", out_valid, 1);
        check("post_rst_z", z, 132);
        check("post_rst_tag", tag_out, 3);

        // Exhaustive sweep on the W=4, L=2, TRUNC_COL=0 instance
        for (int i = 0; i < 512 + 4; i++) begin
            exp_t e;
            @(negedge clk);
            #1;
            if (b_out_valid) begin
                if (bq.size() == 0) begin
                    check("b_spurious_result", 1, 0);
                end else begin
                    e = bq.pop_front();
                    check("b_z", b_z, e.z);
                    check("b_tag", b_tag_out, e.tag);
                    check("b_mode", b_out_mode, e.mode);
                end
            end
            if (i < 512) begin
                b_in_valid = 1'b1;
                b_x = 4'(i); b_y = 4'(i >> 4); b_mode = i[8]; b_tag_in = 4'(i);
                e.z    = 16'(ref_mul(4, 2, 0, 64'(b_x), 64'(b_y), b_mode));
                e.tag  = b_tag_in;
                e.mode = b_mode;
                if (b_in_ready) bq.push_back(e);
            end else begin
                b_in_valid = 1'b0;
            end
        end
        check("b_all_returned", bq.size(), 0);
        check("a_all_returned", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
